// File: rtl/alu_result_wb.sv
// rtl/alu_result_wb.sv - ALU result write-back into a single-port register file
//
// Purpose:
//   Accepts one ALU result per valid/ready handshake and commits it to the
//   register file. Results carrying a high half are written as two commits:
//   low half to rd, then high half to rd+1 (mod 2^REG_AW). Register 0 is
//   hardwired zero, so any commit addressed to it suppresses rf_we.
//
// Optional feature (macro ALU_WB_HI_REG_EN):
//   When defined, the high half is latched into hi_q at the accept edge
//   instead of being written to rd+1, so the pipeline never stalls.
//   When undefined, hi_q is held at 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   result handshake (in_ready depends on state and rst only)
//   in_rd               destination register for the low half
//   in_low, in_high     ALU result halves
//   in_write_high       high half must also be committed
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   busy                a commit is on the write port (state != IDLE)
//   hi_q                dedicated HI register
module alu_result_wb #(
  parameter int REG_AW = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_low,
  input  logic [DATA_W-1:0] in_high,
  input  logic              in_write_high,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic [DATA_W-1:0] hi_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                pend_high_q;
  logic [DATA_W-1:0]   hi_data_q;
  logic [REG_AW-1:0]   hi_addr_q;
  logic                accept;
  logic                issue_high;

  // The only stall is the cycle the low half of a pair occupies the write
  // port while its high half still waits to go out.
  always_comb begin
    issue_high = (state_q == LO) && pend_high_q;
    in_ready   = !rst && !issue_high;
    accept     = in_valid && in_ready;
    state_d    = IDLE;
    if (accept) begin
      state_d = LO;
    end else if (issue_high) begin
      state_d = HI;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_high_q <= 1'b0;
      hi_data_q   <= '0;
      hi_addr_q   <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rf_we     <= (in_rd != '0);
        rf_waddr  <= in_rd;
        rf_wdata  <= in_low;
`ifdef ALU_WB_HI_REG_EN
        pend_high_q <= 1'b0;
`else
        pend_high_q <= in_write_high;
`endif
        hi_data_q <= in_high;
        // Natural wrap: rd = all-ones pairs with register 0.
        hi_addr_q <= in_rd + REG_AW'(1);
      end else if (issue_high) begin
        rf_we       <= (hi_addr_q != '0);
        rf_waddr    <= hi_addr_q;
        rf_wdata    <= hi_data_q;
        pend_high_q <= 1'b0;
      end else begin
        // Address/data hold their last value; only the enable drops.
        rf_we <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);

`ifdef ALU_WB_HI_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
    end else if (accept && in_write_high) begin
      hi_q <= in_high;
    end
  end
`else
  assign hi_q = '0;
`endif

endmodule

// File: tb/tb_alu_result_wb.sv
// tb/tb_alu_result_wb.sv - self-checking bench for alu_result_wb
module tb_alu_result_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rd;
  logic [15:0] in_low;
  logic [15:0] in_high;
  logic        in_write_high;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        busy;
  logic [15:0] hi_q;

  always #5 clk = ~clk;

  alu_result_wb #(.REG_AW(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_low(in_low), .in_high(in_high),
    .in_write_high(in_write_high),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .hi_q(hi_q)
  );

  // Reference model: a schedule of write-port slots keyed by cycle number.
  // cyc counts rising edges; outputs seen while cyc==N result from edge N.
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          armed = 0;
  bit          last_acc;
  bit          exp_v [int];
  logic [3:0]  exp_a [int];
  logic [15:0] exp_d [int];
  logic [15:0] mhi = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ready unless in reset or a high half already owns the next slot.
  function automatic bit model_ready();
    return !rst && !exp_v.exists(cyc + 1);
  endfunction

  task automatic tick();
    bit acc;
    logic [3:0] a1;
    @(posedge clk);
    acc = in_valid && model_ready();
    cyc++;
    if (rst) begin
      exp_v.delete();
      mhi = '0;
    end else if (acc) begin
      exp_v[cyc] = 1'b1;
      exp_a[cyc] = in_rd;
      exp_d[cyc] = in_low;
`ifdef ALU_WB_HI_REG_EN
      if (in_write_high) mhi = in_high;
`else
      if (in_write_high) begin
        a1 = in_rd + 4'd1;
        exp_v[cyc+1] = 1'b1;
        exp_a[cyc+1] = a1;
        exp_d[cyc+1] = in_high;
      end
`endif
    end
    last_acc = acc;
    #1;
  endtask

  task automatic drive(input bit v, input logic [3:0] rd, input logic [15:0] lo,
                       input logic [15:0] hi, input bit wh);
    in_valid = v; in_rd = rd; in_low = lo; in_high = hi; in_write_high = wh;
  endtask

  // Present a result and hold it until the model says it was taken.
  task automatic send(input logic [3:0] rd, input logic [15:0] lo,
                      input logic [15:0] hi, input bit wh);
    int n = 0;
    drive(1'b1, rd, lo, hi, wh);
    do begin
      tick();
      n++;
    end while (!last_acc && n < 8);
    if (!last_acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", in_ready, model_ready());
      if (exp_v.exists(cyc)) begin
        chk("busy", busy, 1);
        chk("rf_we", rf_we, exp_a[cyc] != 4'd0);
        chk("rf_waddr", rf_waddr, exp_a[cyc]);
        chk("rf_wdata", rf_wdata, exp_d[cyc]);
      end else begin
        chk("busy_idle", busy, 0);
        chk("rf_we_idle", rf_we, 0);
      end
      chk("hi_q", hi_q, mhi);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
    tick();
    armed = 1;
    tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hi_q", hi_q, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1);

    // Single 16-bit result.
    send(4'd3, 16'h1234, 16'h0000, 1'b0);
    chk("add_we", rf_we, 1);
    chk("add_waddr", rf_waddr, 3);
    chk("add_wdata", rf_wdata, 16'h1234);
    idle(1);
    chk("add_done_we", rf_we, 0);
    chk("add_done_busy", busy, 0);

    // MUL pair with a second result queued behind it.
    drive(1'b1, 4'd5, 16'hBEEF, 16'h00DE, 1'b1);
    tick();
    chk("mul_lo_addr", rf_waddr, 5);
    chk("mul_lo_data", rf_wdata, 16'hBEEF);
    drive(1'b1, 4'd7, 16'h7777, 16'h0000, 1'b0);
`ifdef ALU_WB_HI_REG_EN
    chk("hi_lo_ready", in_ready, 1);
    tick();
    chk("hi_hi_q", hi_q, 16'h00DE);
    chk("hi_next_addr", rf_waddr, 7);
    chk("hi_next_data", rf_wdata, 16'h7777);
`else
    chk("mul_lo_ready", in_ready, 0);
    tick();
    chk("mul_hi_addr", rf_waddr, 6);
    chk("mul_hi_data", rf_wdata, 16'h00DE);
    chk("mul_hi_ready", in_ready, 1);
    tick();
    chk("mul_next_addr", rf_waddr, 7);
    chk("mul_next_data", rf_wdata, 16'h7777);
`endif
    idle(1);

    // Back-to-back 16-bit results.
    for (int i = 1; i <= 4; i++) begin
      send(4'(i), 16'hA000 + 16'(i), 16'h0000, 1'b0);
      chk("b2b_ready", in_ready, 1);
    end
    idle(1);

    // Address wrap into register 0, then a direct write to register 0.
    send(4'd15, 16'h0F0F, 16'hF0F0, 1'b1);
    chk("wrap_lo_we", rf_we, 1);
    chk("wrap_lo_addr", rf_waddr, 15);
    idle(1);
`ifndef ALU_WB_HI_REG_EN
    chk("wrap_hi_addr", rf_waddr, 0);
    chk("wrap_hi_we", rf_we, 0);
    chk("wrap_hi_busy", busy, 1);
`endif
    idle(1);
    send(4'd0, 16'h5555, 16'h0000, 1'b0);
    chk("x0_we", rf_we, 0);
    chk("x0_busy", busy, 1);
    idle(1);

    // Reset during the low half of a pair.
    send(4'd9, 16'h1111, 16'h2222, 1'b1);
    drive(1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
    rst = 1'b1;
    tick();
    chk("midrst_we", rf_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_hi_q", hi_q, 0);
    rst = 1'b0;
    #1;
    chk("midrst_ready", in_ready, 1);
    idle(3);

    // A few mixed results through the model only.
    send(4'd2, 16'hCAFE, 16'h0001, 1'b1);
    send(4'd8, 16'h0008, 16'h0000, 1'b0);
    send(4'd14, 16'hFFFF, 16'h8000, 1'b1);
    send(4'd1, 16'h0101, 16'h0000, 1'b0);
    idle(3);

    armed = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
